ghost_mode_sequencer: RTL

//  Global scatter/chase mode timer for all four ghosts; drives isChase/isScatter of blinky
//  and siblings. Counts frame_tick pulses through the arcade level-1 schedule
//  (S7 C20 S7 C20 S5 C20 S5 C-forever). Emits a one-cycle reverse pulse on every mode change.

---
 rtl/ghost_mode_sequencer.sv | 73 +++++++
 1 files changed

// File: rtl/ghost_mode_sequencer.sv
// rtl/ghost_mode_sequencer.sv - global scatter/chase schedule timer driving all four ghosts
module ghost_mode_sequencer #(
  parameter int SCATTER_LONG  = 420,
  parameter int SCATTER_SHORT = 300,
  parameter int CHASE_LEN     = 1200,
  parameter int CNT_W         = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       frightened,
  input  logic       restart,
  output logic       isChase,
  output logic       isScatter,
  output logic [2:0] phase,
  output logic       reverse_pulse
);

  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] dur_m1;
  logic             adv;

  // Terminal count of the current phase; phase 7 never reaches a compare since adv is masked.
  always_comb begin
    dur_m1 = CNT_W'(CHASE_LEN - 1);
    case (phase_q)
      3'd0, 3'd2: dur_m1 = CNT_W'(SCATTER_LONG - 1);
      3'd4, 3'd6: dur_m1 = CNT_W'(SCATTER_SHORT - 1);
      default:    dur_m1 = CNT_W'(CHASE_LEN - 1);
    endcase
  end

  assign adv = frame_tick & enable & ~frightened & ~restart & (phase_q != 3'd7);

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (restart) begin
      phase_d = 3'd0;
      cnt_d   = '0;
    end else if (adv) begin
      if (cnt_q == dur_m1) begin
        cnt_d   = '0;
        phase_d = phase_q + 3'd1;
        pulse_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 3'd0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign phase         = phase_q;
  assign isChase       = phase_q[0];
  assign isScatter     = ~phase_q[0];
  assign reverse_pulse = pulse_q;

endmodule
